// File: rtl/disp_fetch_if.sv
// Display-fetch bundle: VRAM AXI4 read channel, display buffer write port and control/status.
// master is the fetch controller's view; slave is the VRAM/buffer/timing side.
interface disp_fetch_if;
  logic        DISPON;
  logic        VSTART;
  logic [31:0] VRAMADDR;
  logic        BUF_WREADY;
  logic        FIFORST;
  logic [63:0] FIFOIN;
  logic        FIFOWR;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic        ARVALID;
  logic        ARREADY;
  logic [63:0] RDATA;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        BUSY;
  logic        ERR;

  modport master (
    input  DISPON, VSTART, VRAMADDR, BUF_WREADY, ARREADY, RDATA, RLAST, RVALID,
    output FIFORST, FIFOIN, FIFOWR, ARADDR, ARLEN, ARVALID, RREADY, BUSY, ERR
  );

  modport slave (
    output DISPON, VSTART, VRAMADDR, BUF_WREADY, ARREADY, RDATA, RLAST, RVALID,
    input  FIFORST, FIFOIN, FIFOWR, ARADDR, ARLEN, ARVALID, RREADY, BUSY, ERR
  );
endinterface

// File: rtl/disp_fetch_ctrl.sv
// Frame-fetch controller: once per frame, streams the VRAM image into the display FIFO
// using fixed-length AXI4 read bursts, one outstanding burst at a time.
module disp_fetch_ctrl #(
  parameter int unsigned FRAME_BEATS = 153600,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned RST_CYCLES  = 8
) (
  input  logic        ACLK,
  input  logic        ARSTN,
  disp_fetch_if.master io_bus
);

  localparam int unsigned NumBursts = FRAME_BEATS / BURST_LEN;
  localparam int unsigned RemW      = $clog2(NumBursts + 1);
  localparam int unsigned BeatW     = $clog2(BURST_LEN);
  localparam int unsigned RstW      = $clog2(RST_CYCLES + 1);

  localparam logic [31:0]      AddrStep = 32'(BURST_LEN * 8);
  localparam logic [RemW-1:0]  RemInit  = RemW'(NumBursts);
  localparam logic [BeatW-1:0] BeatLast = BeatW'(BURST_LEN - 1);
  localparam logic [RstW-1:0]  RstLast  = RstW'(RST_CYCLES - 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StFrst = 3'd1;
  localparam logic [2:0] StWait = 3'd2;
  localparam logic [2:0] StAddr = 3'd3;
  localparam logic [2:0] StData = 3'd4;

  logic [2:0]       r_state, w_state_nxt;
  logic [31:0]      r_addr, w_addr_nxt;
  logic [31:0]      r_araddr, w_araddr_nxt;
  logic [RemW-1:0]  r_rem, w_rem_nxt;
  logic [BeatW-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic [RstW-1:0]  r_rst_cnt, w_rst_cnt_nxt;
  logic             r_restart, w_restart_nxt;
  logic             r_err, w_err_nxt;
  logic [63:0]      r_fifoin;
  logic             r_fifowr;

  logic        w_vstart_acc;
  logic        w_ar_hs;
  logic        w_beat;
  logic        w_rlast_err;
  logic [31:0] w_base;
  logic        w_unused_addr;

  assign w_vstart_acc  = io_bus.VSTART & io_bus.DISPON;
  assign w_ar_hs       = (r_state == StAddr) & io_bus.ARREADY;
  // RREADY is high for the whole of DATA, so RVALID alone qualifies a beat there.
  assign w_beat        = (r_state == StData) & io_bus.RVALID;
  assign w_rlast_err   = w_beat & (io_bus.RLAST != (r_beat_cnt == BeatLast));
  assign w_base        = {io_bus.VRAMADDR[31:7], 7'b0};
  assign w_unused_addr = ^io_bus.VRAMADDR[6:0];

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_araddr_nxt   = r_araddr;
    w_rem_nxt      = r_rem;
    w_beat_cnt_nxt = r_beat_cnt;
    w_rst_cnt_nxt  = r_rst_cnt;
    w_restart_nxt  = r_restart;
    w_err_nxt      = r_err;

    unique case (r_state)
      StIdle: begin
        if (w_vstart_acc) begin
          w_state_nxt   = StFrst;
          w_rst_cnt_nxt = '0;
        end
      end
      StFrst: begin
        if (w_vstart_acc) begin
          w_rst_cnt_nxt = '0;
        end else if (r_rst_cnt == RstLast) begin
          w_state_nxt = StWait;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + 1'b1;
        end
      end
      StWait: begin
        // A new frame start wins over both the frame-done and the display-off exits.
        if (r_restart || w_vstart_acc) begin
          w_state_nxt   = StFrst;
          w_rst_cnt_nxt = '0;
        end else if (!io_bus.DISPON || (r_rem == '0)) begin
          w_state_nxt = StIdle;
        end else if (io_bus.BUF_WREADY) begin
          w_state_nxt  = StAddr;
          w_araddr_nxt = r_addr;
        end
      end
      StAddr: begin
        if (w_ar_hs) begin
          w_state_nxt = StData;
          w_addr_nxt  = r_addr + AddrStep;
          w_rem_nxt   = r_rem - 1'b1;
        end
      end
      StData: begin
        if (w_beat) begin
          if (io_bus.RLAST) begin
            w_state_nxt    = StWait;
            w_beat_cnt_nxt = '0;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase

    if (w_state_nxt == StFrst) begin
      w_restart_nxt = 1'b0;
    end else if (w_vstart_acc) begin
      w_restart_nxt = 1'b1;
    end

    // The re-latch overrides the handshake increment; ARADDR lives in its own register.
    if (w_vstart_acc) begin
      w_addr_nxt = w_base;
      w_rem_nxt  = RemInit;
      w_err_nxt  = 1'b0;
    end
    if (w_rlast_err) begin
      w_err_nxt = 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARSTN) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_araddr   <= '0;
      r_rem      <= '0;
      r_beat_cnt <= '0;
      r_rst_cnt  <= '0;
      r_restart  <= 1'b0;
      r_err      <= 1'b0;
      r_fifoin   <= '0;
      r_fifowr   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_araddr   <= w_araddr_nxt;
      r_rem      <= w_rem_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_rst_cnt  <= w_rst_cnt_nxt;
      r_restart  <= w_restart_nxt;
      r_err      <= w_err_nxt;
      r_fifowr   <= w_beat;
      if (w_beat) begin
        r_fifoin <= io_bus.RDATA;
      end
    end
  end

  assign io_bus.FIFORST = (r_state == StFrst);
  assign io_bus.ARVALID = (r_state == StAddr);
  assign io_bus.RREADY  = (r_state == StData);
  assign io_bus.BUSY    = (r_state != StIdle);
  assign io_bus.ARADDR  = r_araddr;
  assign io_bus.ARLEN   = 8'(BURST_LEN - 1);
  assign io_bus.FIFOIN  = r_fifoin;
  assign io_bus.FIFOWR  = r_fifowr;
  assign io_bus.ERR     = r_err;

endmodule

// File: tb/tb_disp_fetch_ctrl.sv
// Bench for disp_fetch_ctrl: background AXI read slave feeding a data scoreboard, plus
// per-scenario tasks checking framing, addressing, flow control, restart and error handling.
module tb_disp_fetch_ctrl;
  localparam int unsigned FrameBeats = 64;
  localparam int unsigned BurstLen   = 16;
  localparam int unsigned RstCycles  = 8;

  logic aclk = 1'b0;
  logic arstn;
  always #5 aclk = ~aclk;

  disp_fetch_if bus ();

  disp_fetch_ctrl #(
    .FRAME_BEATS(FrameBeats),
    .BURST_LEN  (BurstLen),
    .RST_CYCLES (RstCycles)
  ) dut (
    .ACLK  (aclk),
    .ARSTN (arstn),
    .io_bus(bus)
  );

  int vectors;
  int miscompares;

  logic [63:0] exp_q[$];
  logic [31:0] ar_log[$];

  int fifowr_cnt, rhs_cnt, arvalid_cycles, araddr_unstable;
  int rst_pulses, rst_run, rst_last_len, wr_at_rst;
  int ar_delay, rlast_at;
  bit gaps_en;

  // Slave and monitor share one negedge process so sampling precedes driving.
  task automatic slave_monitor();
    bit          s_active = 1'b0;
    int          s_wait = 0;
    int          s_beats = 0;
    logic [31:0] s_addr = '0;
    bit          prev_beat = 1'b0;
    bit          prev_arvalid = 1'b0;
    logic [31:0] prev_araddr = '0;
    logic [63:0] rd;
    forever begin
      @(negedge aclk);
      if (!arstn) begin
        s_active     = 1'b0;
        s_wait       = 0;
        prev_beat    = 1'b0;
        prev_arvalid = 1'b0;
        rst_run      = 0;
        bus.ARREADY  = 1'b0;
        bus.RVALID   = 1'b0;
        bus.RLAST    = 1'b0;
        exp_q.delete();
      end else begin
        if (bus.FIFOWR || prev_beat) begin
          vectors++;
          if (bus.FIFOWR !== prev_beat) begin
            miscompares++;
            $display("FAIL fifowr_latency: FIFOWR=%b, required %b", bus.FIFOWR, prev_beat);
          end
        end
        if (bus.FIFOWR === 1'b1) begin
          fifowr_cnt++;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL fifoin_extra: FIFOWR with FIFOIN=%h, required no write", bus.FIFOIN);
          end else begin
            rd = exp_q.pop_front();
            if (bus.FIFOIN !== rd) begin
              miscompares++;
              $display("FAIL fifoin_data: FIFOIN=%h, required %h", bus.FIFOIN, rd);
            end
          end
        end
        if (bus.ARVALID) begin
          arvalid_cycles++;
          if (prev_arvalid && (bus.ARADDR !== prev_araddr)) araddr_unstable++;
        end
        if (bus.FIFORST) begin
          if (rst_run == 0) begin
            rst_pulses++;
            wr_at_rst = fifowr_cnt;
          end
          rst_run++;
        end else if (rst_run != 0) begin
          rst_last_len = rst_run;
          rst_run      = 0;
        end
        prev_arvalid = bus.ARVALID;
        prev_araddr  = bus.ARADDR;

        if (bus.ARREADY) begin
          bus.ARREADY = 1'b0;
          ar_log.push_back(s_addr);
          s_active = 1'b1;
          s_beats  = 0;
        end else if (bus.RVALID) begin
          s_beats++;
          if (bus.RLAST) s_active = 1'b0;
        end
        bus.RVALID = 1'b0;
        bus.RLAST  = 1'b0;
        if (!s_active && bus.ARVALID) begin
          if (s_wait >= ar_delay) begin
            bus.ARREADY = 1'b1;
            s_addr      = bus.ARADDR;
            s_wait      = 0;
          end else begin
            s_wait++;
          end
        end
        if (s_active && !(gaps_en && ($urandom_range(0, 2) == 0))) begin
          rd         = {$urandom, $urandom};
          bus.RDATA  = rd;
          bus.RLAST  = (s_beats == rlast_at);
          bus.RVALID = 1'b1;
          exp_q.push_back(rd);
        end
        prev_beat = bus.RVALID && bus.RREADY;
        if (prev_beat) rhs_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(negedge aclk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_vstart(input logic [31:0] addr);
    bus.VRAMADDR = addr;
    bus.VSTART   = 1'b1;
    tick();
    bus.VSTART   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (bus.BUSY && (n < budget)) begin
      tick();
      n++;
    end
    vectors++;
    if (bus.BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle_timeout: BUSY=%b after %0d cycles, required 0", tag, bus.BUSY, n);
    end
  endtask

  task automatic wait_wr(input int target, input string tag);
    int n = 0;
    while ((fifowr_cnt < target) && (n < 200)) begin
      tick();
      n++;
    end
    vectors++;
    if (fifowr_cnt < target) begin
      miscompares++;
      $display("FAIL %s_wr_timeout: writes=%0d, required >= %0d", tag, fifowr_cnt, target);
    end
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    ticks(3);
    vectors++;
    if ({bus.FIFORST, bus.FIFOWR, bus.ARVALID, bus.RREADY, bus.BUSY, bus.ERR} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: {FIFORST,FIFOWR,ARVALID,RREADY,BUSY,ERR}=%b, required 000000",
               {bus.FIFORST, bus.FIFOWR, bus.ARVALID, bus.RREADY, bus.BUSY, bus.ERR});
    end
    vectors++;
    if (bus.FIFOIN !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_fifoin: FIFOIN=%h, required 0", bus.FIFOIN);
    end
    vectors++;
    if (bus.ARADDR !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_araddr: ARADDR=%h, required 0", bus.ARADDR);
    end
    vectors++;
    if (bus.ARLEN !== 8'h0F) begin
      miscompares++;
      $display("FAIL arlen: ARLEN=%h, required 0f", bus.ARLEN);
    end
    arstn = 1'b1;
    ticks(2);
  endtask

  task automatic test_basic_frame();
    int wr0 = fifowr_cnt;
    int ar0 = ar_log.size();
    int rp0 = rst_pulses;
    int av0;
    bus.DISPON     = 1'b1;
    bus.BUF_WREADY = 1'b1;
    pulse_vstart(32'h1000_0040);
    vectors++;
    if ({bus.FIFORST, bus.BUSY, bus.ARVALID} !== 3'b110) begin
      miscompares++;
      $display("FAIL frst_entry: {FIFORST,BUSY,ARVALID}=%b, required 110",
               {bus.FIFORST, bus.BUSY, bus.ARVALID});
    end
    wait_idle(400, "basic");
    vectors++;
    if ((rst_pulses - rp0 != 1) || (rst_last_len != RstCycles)) begin
      miscompares++;
      $display("FAIL basic_fiforst: pulses=%0d len=%0d, required 1 and %0d",
               rst_pulses - rp0, rst_last_len, RstCycles);
    end
    vectors++;
    if (ar_log.size() - ar0 != 4) begin
      miscompares++;
      $display("FAIL basic_bursts: bursts=%0d, required 4", ar_log.size() - ar0);
    end else begin
      vectors++;
      if ({ar_log[ar0], ar_log[ar0+1], ar_log[ar0+3]} !== {32'h1000_0000, 32'h1000_0080,
                                                           32'h1000_0180}) begin
        miscompares++;
        $display("FAIL basic_araddr: %h %h %h, required 10000000 10000080 10000180",
                 ar_log[ar0], ar_log[ar0+1], ar_log[ar0+3]);
      end
    end
    vectors++;
    if ((fifowr_cnt - wr0 != 64) || (exp_q.size() != 0)) begin
      miscompares++;
      $display("FAIL basic_writes: writes=%0d pending=%0d, required 64 and 0",
               fifowr_cnt - wr0, exp_q.size());
    end
    av0 = arvalid_cycles;
    ticks(20);
    vectors++;
    if ((arvalid_cycles != av0) || (bus.BUSY !== 1'b0) || (bus.ERR !== 1'b0)) begin
      miscompares++;
      $display("FAIL basic_quiet: ARVALID cycles=%0d BUSY=%b ERR=%b, required 0 0 0",
               arvalid_cycles - av0, bus.BUSY, bus.ERR);
    end
  endtask

  task automatic test_buf_wready();
    int wr0 = fifowr_cnt;
    int av0 = arvalid_cycles;
    bus.BUF_WREADY = 1'b0;
    pulse_vstart(32'h0400_0000);
    ticks(RstCycles + 50);
    vectors++;
    if ((arvalid_cycles != av0) || (bus.BUSY !== 1'b1) || (bus.FIFORST !== 1'b0)) begin
      miscompares++;
      $display("FAIL bufw_hold: ARVALID cycles=%0d BUSY=%b FIFORST=%b, required 0 1 0",
               arvalid_cycles - av0, bus.BUSY, bus.FIFORST);
    end
    bus.BUF_WREADY = 1'b1;
    tick();
    vectors++;
    if ((bus.ARVALID !== 1'b1) || (bus.ARADDR !== 32'h0400_0000)) begin
      miscompares++;
      $display("FAIL bufw_release: ARVALID=%b ARADDR=%h, required 1 04000000",
               bus.ARVALID, bus.ARADDR);
    end
    wait_idle(400, "bufw");
    vectors++;
    if (fifowr_cnt - wr0 != 64) begin
      miscompares++;
      $display("FAIL bufw_writes: writes=%0d, required 64", fifowr_cnt - wr0);
    end
  endtask

  task automatic test_delays();
    int wr0 = fifowr_cnt;
    int rh0 = rhs_cnt;
    int av0 = arvalid_cycles;
    int un0 = araddr_unstable;
    ar_delay = 5;
    gaps_en  = 1'b1;
    pulse_vstart(32'h0800_0000);
    wait_idle(1000, "delay");
    vectors++;
    if ((araddr_unstable != un0) || (arvalid_cycles - av0 != 4 * (ar_delay + 1))) begin
      miscompares++;
      $display("FAIL delay_ar: unstable=%0d ARVALID cycles=%0d, required 0 and %0d",
               araddr_unstable - un0, arvalid_cycles - av0, 4 * (ar_delay + 1));
    end
    vectors++;
    if ((fifowr_cnt - wr0 != rhs_cnt - rh0) || (fifowr_cnt - wr0 != 64)) begin
      miscompares++;
      $display("FAIL delay_writes: writes=%0d beats=%0d, required both 64",
               fifowr_cnt - wr0, rhs_cnt - rh0);
    end
    vectors++;
    if (ar_log[ar_log.size()-1] !== 32'h0800_0180) begin
      miscompares++;
      $display("FAIL delay_lastaddr: ARADDR=%h, required 08000180", ar_log[ar_log.size()-1]);
    end
    ar_delay = 0;
    gaps_en  = 1'b0;
  endtask

  task automatic test_restart();
    int wr0 = fifowr_cnt;
    int ar0 = ar_log.size();
    int rp0 = rst_pulses;
    pulse_vstart(32'h1000_0000);
    wait_wr(wr0 + 7, "restart");
    pulse_vstart(32'h2000_0000);
    wait_idle(500, "restart");
    vectors++;
    if (ar_log.size() - ar0 != 5) begin
      miscompares++;
      $display("FAIL restart_bursts: bursts=%0d, required 5", ar_log.size() - ar0);
    end else begin
      vectors++;
      if ({ar_log[ar0], ar_log[ar0+1]} !== {32'h1000_0000, 32'h2000_0000}) begin
        miscompares++;
        $display("FAIL restart_araddr: %h %h, required 10000000 20000000",
                 ar_log[ar0], ar_log[ar0+1]);
      end
    end
    vectors++;
    if ((rst_pulses - rp0 != 2) || (rst_last_len != RstCycles) || (wr_at_rst - wr0 != 16)) begin
      miscompares++;
      $display("FAIL restart_fiforst: pulses=%0d len=%0d writes_before=%0d, required 2 %0d 16",
               rst_pulses - rp0, rst_last_len, wr_at_rst - wr0, RstCycles);
    end
    vectors++;
    if (fifowr_cnt - wr0 != 80) begin
      miscompares++;
      $display("FAIL restart_writes: writes=%0d, required 80", fifowr_cnt - wr0);
    end
  endtask

  task automatic test_err();
    int wr0 = fifowr_cnt;
    int n = 0;
    rlast_at = 10;
    pulse_vstart(32'h3000_0000);
    while ((bus.ERR !== 1'b1) && (n < 100)) begin
      tick();
      n++;
    end
    vectors++;
    if ((bus.ERR !== 1'b1) || (fifowr_cnt - wr0 != 11)) begin
      miscompares++;
      $display("FAIL err_set: ERR=%b writes=%0d, required 1 and 11", bus.ERR, fifowr_cnt - wr0);
    end
    rlast_at = BurstLen - 1;
    wait_idle(400, "err");
    vectors++;
    if ((bus.ERR !== 1'b1) || (fifowr_cnt - wr0 != 59)) begin
      miscompares++;
      $display("FAIL err_sticky: ERR=%b writes=%0d, required 1 and 59", bus.ERR, fifowr_cnt - wr0);
    end
    pulse_vstart(32'h3000_0000);
    vectors++;
    if (bus.ERR !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: ERR=%b, required 0", bus.ERR);
    end
    wait_idle(400, "err2");
    vectors++;
    if (bus.ERR !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clean_frame: ERR=%b, required 0", bus.ERR);
    end
  endtask

  task automatic test_dispon_off();
    int wr0 = fifowr_cnt;
    int ar0 = ar_log.size();
    int rp0 = rst_pulses;
    pulse_vstart(32'h0C00_0000);
    wait_wr(wr0 + 5, "dispoff");
    bus.DISPON = 1'b0;
    wait_idle(200, "dispoff");
    vectors++;
    if ((fifowr_cnt - wr0 != 16) || (ar_log.size() - ar0 != 1) || (rst_pulses - rp0 != 1) ||
        (exp_q.size() != 0)) begin
      miscompares++;
      $display("FAIL dispoff_stop: writes=%0d bursts=%0d pulses=%0d pending=%0d, required 16 1 1 0",
               fifowr_cnt - wr0, ar_log.size() - ar0, rst_pulses - rp0, exp_q.size());
    end
    pulse_vstart(32'h0C00_0000);
    ticks(2);
    vectors++;
    if ((bus.BUSY !== 1'b0) || (bus.FIFORST !== 1'b0)) begin
      miscompares++;
      $display("FAIL dispoff_vstart_ignored: BUSY=%b FIFORST=%b, required 0 0",
               bus.BUSY, bus.FIFORST);
    end
    bus.DISPON = 1'b1;
  endtask

  task automatic test_reset_mid();
    int wr0 = fifowr_cnt;
    int av0;
    int ar0;
    int rp0;
    pulse_vstart(32'h1400_0000);
    wait_wr(wr0 + 4, "rstmid");
    pulse_vstart(32'h1500_0000);
    arstn = 1'b0;
    tick();
    vectors++;
    if ({bus.FIFORST, bus.FIFOWR, bus.ARVALID, bus.RREADY, bus.BUSY, bus.ERR} !== 6'b0) begin
      miscompares++;
      $display("FAIL rstmid_ctrl: {FIFORST,FIFOWR,ARVALID,RREADY,BUSY,ERR}=%b, required 000000",
               {bus.FIFORST, bus.FIFOWR, bus.ARVALID, bus.RREADY, bus.BUSY, bus.ERR});
    end
    vectors++;
    if ((bus.FIFOIN !== 64'h0) || (bus.ARADDR !== 32'h0)) begin
      miscompares++;
      $display("FAIL rstmid_data: FIFOIN=%h ARADDR=%h, required 0 0", bus.FIFOIN, bus.ARADDR);
    end
    arstn = 1'b1;
    av0 = arvalid_cycles;
    ticks(20);
    vectors++;
    if ((bus.BUSY !== 1'b0) || (arvalid_cycles != av0)) begin
      miscompares++;
      $display("FAIL rstmid_quiet: BUSY=%b ARVALID cycles=%0d, required 0 0",
               bus.BUSY, arvalid_cycles - av0);
    end
    wr0 = fifowr_cnt;
    ar0 = ar_log.size();
    rp0 = rst_pulses;
    pulse_vstart(32'h1800_0000);
    wait_idle(400, "recover");
    vectors++;
    if ((fifowr_cnt - wr0 != 64) || (rst_pulses - rp0 != 1) || (ar_log.size() - ar0 != 4)) begin
      miscompares++;
      $display("FAIL recover_frame: writes=%0d pulses=%0d bursts=%0d, required 64 1 4",
               fifowr_cnt - wr0, rst_pulses - rp0, ar_log.size() - ar0);
    end else begin
      vectors++;
      if (ar_log[ar0] !== 32'h1800_0000) begin
        miscompares++;
        $display("FAIL recover_araddr: ARADDR=%h, required 18000000", ar_log[ar0]);
      end
    end
  endtask

  initial begin
    arstn          = 1'b0;
    bus.DISPON     = 1'b0;
    bus.VSTART     = 1'b0;
    bus.VRAMADDR   = '0;
    bus.BUF_WREADY = 1'b0;
    bus.ARREADY    = 1'b0;
    bus.RDATA      = '0;
    bus.RLAST      = 1'b0;
    bus.RVALID     = 1'b0;
    vectors        = 0;
    miscompares    = 0;
    ar_delay       = 0;
    rlast_at       = BurstLen - 1;
    gaps_en        = 1'b0;
    fork
      slave_monitor();
    join_none
    test_reset();
    test_basic_frame();
    test_buf_wready();
    test_delays();
    test_restart();
    test_err();
    test_dispon_off();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
